// File: rtl/aes128_inv_round_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per clk, round keys fetched by index.
// Optional synchronous flush port `abort` is built in when AES_INV_ABORT_EN is defined.
module aes128_inv_round_iter #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      ct,
  output logic [KIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      pt,
`ifdef AES_INV_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_t;

  // Byte x of the inverse S-box sits at bits [2047-8x -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127-8*k -: 8] = INV_SBOX[2047-8*int'(s[127-8*k -: 8]) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(r+4*c) -: 8];
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      // Circulant rows of {0e,0b,0d,09}.
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return o;
  endfunction

  fsm_t              r_fsm;
  logic [127:0]      r_state;
  logic [127:0]      r_pt;
  logic [KIDX_W-1:0] r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [127:0]      w_ark;
  logic [127:0]      w_imc;
  logic [KIDX_W-1:0] w_rk_idx;
  logic              w_abort;

`ifdef AES_INV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_ark = inv_sub_bytes(inv_shift_rows(r_state)) ^ rk;
  assign w_imc = inv_mix_columns(w_ark);

  // Key index depends only on FSM state and counter, never on rk.
  always_comb begin
    w_rk_idx = KIDX_W'(NR);
    if (r_fsm == S_ROUND)      w_rk_idx = r_cnt;
    else if (r_fsm == S_FINAL) w_rk_idx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_pt        <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_abort && (r_fsm != S_IDLE)) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready && !w_abort) begin
            r_state    <= ct ^ rk;
            r_cnt      <= KIDX_W'(NR - 1);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_fsm      <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_state <= w_imc;
          r_cnt   <= r_cnt - KIDX_W'(1);
          if (r_cnt == KIDX_W'(1)) r_fsm <= S_FINAL;
        end
        S_FINAL: begin
          r_pt        <= w_ark;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_fsm       <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_fsm       <= S_IDLE;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign pt        = r_pt;
  assign busy      = r_busy;
  assign rk_idx    = w_rk_idx;

endmodule

// File: tb/tb_aes128_inv_round_iter.sv
// Bench for aes128_inv_round_iter: FIPS-197 vectors plus random blocks checked against
// a byte-array AES-128 decryption model with arithmetically derived S-boxes.
module tb_aes128_inv_round_iter;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ct = '0;
  logic [127:0] rk;
  logic [127:0] pt;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_idx;
`ifdef AES_INV_ABORT_EN
  logic         abort = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk_tab [16];
  int           acc_q [$];
  logic [127:0] out_q [$];

  aes128_inv_round_iter #(.NR(10), .KIDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ct(ct),
    .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready), .pt(pt),
`ifdef AES_INV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rk = rk_tab[rk_idx];

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid && out_ready) out_q.push_back(pt);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]  = s;
      isbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] rkey(input logic [127:0] key, input int rnd);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [127:0] key, input logic [127:0] c);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] k, o;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    k = rkey(key, 10);
    for (int i = 0; i < 16; i++) s[i] = c[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      k = rkey(key, rnd);
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          t[r+4*col] = isbox[s[r+4*((col+4-r)%4)]] ^ k[127-8*(r+4*col) -: 8];
      for (int col = 0; col < 4; col++)
        for (int r = 0; r < 4; r++) begin
          if (rnd == 0) s[r+4*col] = t[r+4*col];
          else begin
            s[r+4*col] = 8'h00;
            for (int j = 0; j < 4; j++)
              s[r+4*col] = s[r+4*col] ^ gmul(coef[(j+4-r)%4], t[j+4*col]);
          end
        end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input logic [127:0] key);
    for (int i = 0; i < 16; i++) rk_tab[i] = (i <= 10) ? rkey(key, i) : '0;
  endtask

  task automatic send(input logic [127:0] c);
    int g;
    g = 0; ct = c; in_valid = 1'b1;
    while (!in_ready && g < 40) begin step(); g++; end
    chki("accept_wait_bound", int'(g < 40), 1);
    step();
    in_valid = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
  endtask

  task automatic take();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chki("take_out_valid_low", int'(out_valid), 0);
  endtask

  initial begin
    logic [127:0] key, c, pt_hold;
    int lat, g, n0, m0, p;
    bit bad;
    build_sboxes();
    load_key(K_C1);

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chki("rst_in_ready", int'(in_ready), 0);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_busy", int'(busy), 0);
    chk("rst_pt", pt, '0);
    chki("rst_rk_idx", int'(rk_idx), 10);
    step(); step();
    rst_n = 1'b1;
    chki("rel_in_ready_before_edge", int'(in_ready), 0);
    step();
    chki("rel_in_ready_first_cycle", int'(in_ready), 1);

    // FIPS-197 C.1 with key-index trace and latency
    chki("c1_idle_rk_idx", int'(rk_idx), 10);
    send(CT_C1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat < 10) begin
        chki($sformatf("c1_rk_idx_%0d", lat), int'(rk_idx), (lat < 9) ? 9 - lat : 0);
        chki($sformatf("c1_busy_%0d", lat), int'(busy), 1);
      end
      step(); lat++;
    end
    chki("c1_latency", lat, 10);
    chk("c1_pt", pt, PT_C1);
    chki("c1_done_busy", int'(busy), 0);
    chki("c1_done_in_ready", int'(in_ready), 0);
    take();
    chki("c1_idle_in_ready", int'(in_ready), 1);
    chk("c1_pt_kept", pt, PT_C1);

    // FIPS-197 appendix B
    load_key(K_B);
    send(CT_B);
    wait_out(lat);
    chki("b_latency", lat, 10);
    chk("b_pt", pt, PT_B);
    take();

    // Back-pressure with ct churning and in_valid held high
    load_key(K_C1);
    n0 = acc_q.size();
    ct = CT_C1; in_valid = 1'b1; g = 0;
    while (!in_ready && g < 40) begin step(); g++; end
    step();
    lat = 0;
    while (!out_valid && lat < 40) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      step(); lat++;
    end
    chki("bp_latency", lat, 10);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (pt !== PT_C1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1'b1;
    end
    chki("bp_stall_stable", int'(bad), 0);
    chk("bp_pt", pt, PT_C1);
    chki("bp_single_accept", acc_q.size(), n0 + 1);
    c = {$urandom, $urandom, $urandom, $urandom};
    ct = c; out_ready = 1'b1; p = cyc;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chki("bp_two_accepts", acc_q.size(), n0 + 2);
    if (acc_q.size() == n0 + 2) chki("bp_accept_cycle", acc_q[n0+1], p + 1);
    wait_out(lat);
    chki("bp2_latency", lat, 10);
    chk("bp2_pt", pt, ref_decrypt(K_C1, c));
    take();

    // Back-to-back, C.1 then B, out_ready tied high
    n0 = acc_q.size(); m0 = out_q.size();
    out_ready = 1'b1; in_valid = 1'b1; ct = CT_C1; g = 0;
    while (acc_q.size() < n0 + 1 && g < 40) begin step(); g++; end
    ct = CT_B;
    while (!out_valid && g < 80) begin step(); g++; end
    load_key(K_B);
    while (acc_q.size() < n0 + 2 && g < 80) begin step(); g++; end
    in_valid = 1'b0;
    while (out_q.size() < m0 + 2 && g < 120) begin step(); g++; end
    out_ready = 1'b0;
    chki("b2b_outputs", out_q.size(), m0 + 2);
    chki("b2b_accepts", acc_q.size(), n0 + 2);
    if (out_q.size() >= m0 + 2) begin
      chk("b2b_pt_c1", out_q[m0], PT_C1);
      chk("b2b_pt_b", out_q[m0+1], PT_B);
    end
    if (acc_q.size() >= n0 + 2) chki("b2b_accept_spacing", acc_q[n0+1] - acc_q[n0], 12);

    // Reset in the middle of the rounds
    load_key(K_C1);
    send(CT_C1);
    g = 0;
    while (rk_idx !== 4'd5 && g < 20) begin step(); g++; end
    chki("mid_reach_cnt5", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chki("mid_rst_in_ready", int'(in_ready), 0);
    chki("mid_rst_busy", int'(busy), 0);
    chki("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_pt", pt, '0);
    chki("mid_rst_rk_idx", int'(rk_idx), 10);
    step();
    rst_n = 1'b1;
    step();
    chki("mid_rel_in_ready", int'(in_ready), 1);
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (out_valid) bad = 1'b1; end
    chki("mid_block_discarded", int'(bad), 0);
    send(CT_C1);
    wait_out(lat);
    chki("mid_rerun_latency", lat, 10);
    chk("mid_rerun_pt", pt, PT_C1);
    take();

    // Random keys and ciphertexts against the reference model
    for (int it = 0; it < 6; it++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      c   = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      send(c);
      wait_out(lat);
      chki($sformatf("rnd%0d_latency", it), lat, 10);
      chk($sformatf("rnd%0d_pt", it), pt, ref_decrypt(key, c));
      repeat ($urandom_range(0, 3)) step();
      chk($sformatf("rnd%0d_pt_hold", it), pt, ref_decrypt(key, c));
      take();
    end

`ifdef AES_INV_ABORT_EN
    load_key(K_C1);
    pt_hold = pt;
    send(CT_C1);
    g = 0;
    while (rk_idx !== 4'd3 && g < 20) begin step(); g++; end
    chki("abort_reach_cnt3", int'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chki("abort_busy", int'(busy), 0);
    chki("abort_in_ready", int'(in_ready), 1);
    chki("abort_rk_idx", int'(rk_idx), 10);
    chk("abort_pt_kept", pt, pt_hold);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin step(); if (out_valid) bad = 1'b1; end
    chki("abort_no_out_valid", int'(bad), 0);
    abort = 1'b1; in_valid = 1'b1; ct = CT_C1;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chki("abort_idle_no_accept", int'(busy), 0);
    chki("abort_idle_in_ready", int'(in_ready), 1);
    send(CT_C1);
    wait_out(lat);
    chki("abort_rerun_latency", lat, 10);
    chk("abort_rerun_pt", pt, PT_C1);
    take();
`else
    pt_hold = pt;
    chk("final_pt_kept", pt_hold, pt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
